// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared types for the rv32 register-file write side.
//   REG_IDX_W / NUM_REGS : register index width and architectural register count
//   reg_idx_t            : register index (x0..x31)
//   wb_req_t             : one register-file write request
// ---------------------------------------------------------------------------
package rv32_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t    rd;
    logic        wr;
    logic [31:0] value;
  } wb_req_t;

endpackage

// File: rtl/rv32_scoreboard.sv
// ---------------------------------------------------------------------------
// rv32_scoreboard
// Pending-destination vector for long-latency results. A bit is set when a
// long-latency op issues to that register and cleared when its result is
// accepted; a set and a clear of the same register in one cycle leaves the
// bit set (the set belongs to the newer issue). x0 is never pending.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_set_en/i_set_idx  : mark a register pending
//   i_clr_en/i_clr_idx  : retire a pending register
//   i_rs1/i_rs2/i_rd    : decode-stage lookup indices
//   i_chk_idx           : extra lookup index (result destination)
//   o_src_hit           : any decode index is pending
//   o_set_pending       : i_set_idx is already pending
//   o_chk_pending       : i_chk_idx is pending
// ---------------------------------------------------------------------------
module rv32_scoreboard
  import rv32_pkg::reg_idx_t;
#(
  parameter int NUM_REGS = rv32_pkg::NUM_REGS
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_set_en,
  input  reg_idx_t i_set_idx,
  input  logic     i_clr_en,
  input  reg_idx_t i_clr_idx,
  input  reg_idx_t i_rs1,
  input  reg_idx_t i_rs2,
  input  reg_idx_t i_rd,
  input  reg_idx_t i_chk_idx,
  output logic     o_src_hit,
  output logic     o_set_pending,
  output logic     o_chk_pending
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;

  function automatic logic pend_at(input logic [NUM_REGS-1:0] vec, input reg_idx_t idx);
    return (idx != '0) && vec[idx];
  endfunction

  // NOTE: every signal assigned in always_comb gets a full default first, so no latch is inferred.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en) w_pending_nxt[i_clr_idx] = 1'b0;
    // Applied after the clear so a same-cycle re-issue keeps the bit set.
    if (i_set_en) w_pending_nxt[i_set_idx] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  assign o_src_hit     = pend_at(r_pending, i_rs1) | pend_at(r_pending, i_rs2) |
                         pend_at(r_pending, i_rd);
  assign o_set_pending = pend_at(r_pending, i_set_idx);
  assign o_chk_pending = pend_at(r_pending, i_chk_idx);

endmodule

// File: rtl/rv32_writeback_arb.sv
// ---------------------------------------------------------------------------
// rv32_writeback_arb
// Merges the in-order pipeline writeback and an out-of-order long-latency
// unit (LU) onto the single register-file write port through one registered
// stage. The pipeline always wins; the LU is back-pressured via ready.
// Tracks outstanding LU destinations and raises a decode hazard stall.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   stall_in                      : pipeline stall (suppresses LU issue)
//   writeback_flush_in            : kills this cycle's pipeline writeback
//   mem_*_in                      : pipeline writeback slot
//   lu_issue_valid_in/_rd_in      : LU op issued from decode
//   lu_result_*_in / _ready_out   : LU result handshake
//   dec_rs1_in/rs2_in/rd_in       : decode-stage register indices
//   hazard_stall_out              : decode must stall
//   rd_out/rd_write_out/rd_value_out : register-file write port (registered)
//   lu_error_out                  : sticky LU protocol error
// ---------------------------------------------------------------------------
module rv32_writeback_arb
  import rv32_pkg::reg_idx_t;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_in,
  input  logic            writeback_flush_in,
  input  logic            mem_valid_in,
  input  reg_idx_t        mem_rd_in,
  input  logic            mem_rd_write_in,
  input  logic [XLEN-1:0] mem_rd_value_in,
  input  logic            lu_issue_valid_in,
  input  reg_idx_t        lu_issue_rd_in,
  input  logic            lu_result_valid_in,
  input  reg_idx_t        lu_result_rd_in,
  input  logic [XLEN-1:0] lu_result_value_in,
  output logic            lu_result_ready_out,
  input  reg_idx_t        dec_rs1_in,
  input  reg_idx_t        dec_rs2_in,
  input  reg_idx_t        dec_rd_in,
  output logic            hazard_stall_out,
  output reg_idx_t        rd_out,
  output logic            rd_write_out,
  output logic [XLEN-1:0] rd_value_out,
  output logic            lu_error_out
);

  logic            w_pipe_wr;
  logic            w_lu_acc;
  logic            w_lu_wr;
  logic            w_issue;
  logic            w_src_hit;
  logic            w_iss_pending;
  logic            w_res_pending;
  logic            w_bypass_hit;
  reg_idx_t        r_rd;
  logic            r_wr;
  logic [XLEN-1:0] r_value;
  logic            r_err;

  assign w_pipe_wr = mem_valid_in && mem_rd_write_in && (mem_rd_in != '0) && !writeback_flush_in;

  // Held low during reset so no result is consumed while the scoreboard is clear.
  assign lu_result_ready_out = reset_n && !w_pipe_wr;
  assign w_lu_acc = lu_result_valid_in && lu_result_ready_out;
  assign w_lu_wr  = w_lu_acc && (lu_result_rd_in != '0);
  assign w_issue  = lu_issue_valid_in && !stall_in && (lu_issue_rd_in != '0);

  rv32_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (reset_n),
    .i_set_en      (w_issue),
    .i_set_idx     (lu_issue_rd_in),
    .i_clr_en      (w_lu_acc),
    .i_clr_idx     (lu_result_rd_in),
    .i_rs1         (dec_rs1_in),
    .i_rs2         (dec_rs2_in),
    .i_rd          (dec_rd_in),
    .i_chk_idx     (lu_result_rd_in),
    .o_src_hit     (w_src_hit),
    .o_set_pending (w_iss_pending),
    .o_chk_pending (w_res_pending)
  );

  // A result accepted this cycle has already cleared its pending bit in the
  // next state but has not reached the register file yet; hold decode one
  // more cycle. w_lu_wr implies a nonzero index, so x0 never matches here.
  assign w_bypass_hit = w_lu_wr && ((lu_result_rd_in == dec_rs1_in) ||
                                    (lu_result_rd_in == dec_rs2_in) ||
                                    (lu_result_rd_in == dec_rd_in));
  assign hazard_stall_out = w_src_hit || w_bypass_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd    <= '0;
      r_wr    <= 1'b0;
      r_value <= '0;
    end else if (w_pipe_wr) begin
      r_rd    <= mem_rd_in;
      r_wr    <= 1'b1;
      r_value <= mem_rd_value_in;
    end else if (w_lu_wr) begin
      r_rd    <= lu_result_rd_in;
      r_wr    <= 1'b1;
      r_value <= lu_result_value_in;
    end else begin
      r_wr    <= 1'b0;
    end
  end

  // Sticky: an unexpected result or a re-issue to a pending register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                                  r_err <= 1'b0;
    else if ((w_lu_wr && !w_res_pending) || (w_issue && w_iss_pending)) r_err <= 1'b1;
  end

  assign rd_out       = r_rd;
  assign rd_write_out = r_wr;
  assign rd_value_out = r_value;
  assign lu_error_out = r_err;

endmodule

// File: doc/rv32_writeback_arb.md
Name: rv32_writeback_arb

Overview:
- Write-side front end of the rv32 register file; drives its rd_in / rd_write_in / rd_value_in from one registered stage.
- Merges two writers onto the single register-file write port:
  - the in-order pipeline writeback from the memory stage;
  - an out-of-order long-latency unit (divider/CSR-style) returning via valid/ready.
- Keeps a 32-bit pending-destination scoreboard and raises a decode hazard stall, so no instruction reads or overwrites a register whose long-latency result is outstanding.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is hardwired zero.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- stall_in  in  1  pipeline stall; blocks scoreboard set on issue
- writeback_flush_in  in  1  kills the pipeline writeback this cycle
- mem_valid_in  in  1  pipeline writeback slot valid
- mem_rd_in  in  5  pipeline destination register
- mem_rd_write_in  in  1  pipeline slot writes rd
- mem_rd_value_in  in  XLEN  pipeline result
- lu_issue_valid_in  in  1  long-latency op issued from decode this cycle
- lu_issue_rd_in  in  5  its destination register
- lu_result_valid_in  in  1  long-latency result offered
- lu_result_rd_in  in  5  result destination
- lu_result_value_in  in  XLEN  result data
- lu_result_ready_out  out  1  result accepted when valid&&ready
- dec_rs1_in  in  5  decode-stage source 1
- dec_rs2_in  in  5  decode-stage source 2
- dec_rd_in  in  5  decode-stage destination
- hazard_stall_out  out  1  decode must stall
- rd_out  out  5  register-file write index
- rd_write_out  out  1  register-file write enable
- rd_value_out  out  XLEN  register-file write data
- lu_error_out  out  1  sticky protocol error

Behaviour:
- Async reset (reset_n low):
  - rd_out=0, rd_write_out=0, rd_value_out=0, scoreboard=0, lu_error_out=0.
  - lu_result_ready_out=0 while reset_n is low.
- pipe_wr = mem_valid_in && mem_rd_write_in && |mem_rd_in && !writeback_flush_in.
- Pipeline has absolute priority; it never stalls.
- lu_result_ready_out = !pipe_wr (combinational).
- lu_acc = lu_result_valid_in && lu_result_ready_out.
- Output register, latency 1, updated at each posedge:
  - if pipe_wr: rd_out<=mem_rd_in, rd_value_out<=mem_rd_value_in, rd_write_out<=1;
  - else if lu_acc && |lu_result_rd_in: load rd_out/rd_value_out from the lu_result inputs, rd_write_out<=1;
  - else rd_write_out<=0; rd_out and rd_value_out hold their previous values.
- An LU result to x0 is accepted and dropped (rd_write_out=0).
- Scoreboard bit r:
  - set on lu_issue_valid_in && !stall_in && lu_issue_rd_in==r && r!=0;
  - cleared on lu_acc && lu_result_rd_in==r;
  - set and clear of the same r in the same cycle: set wins (new issue).
- writeback_flush_in does not clear the scoreboard and does not block LU results; LU ops are committed at issue.
- hazard_stall_out, combinational; x0 never hazards:
  - pending[dec_rs1_in] | pending[dec_rs2_in] | pending[dec_rd_in]
  - | (lu_acc && lu_result_rd_in matches any nonzero dec_* index). This same-cycle case waits one cycle for the registered write to land.
- lu_error_out sets sticky on either:
  - lu_acc for a nonzero rd whose pending bit is 0;
  - issue to an rd already pending.
- The value is still written in both error cases. lu_error_out clears only on reset.
- Mid-operation reset: the scoreboard clears immediately; results in flight after reset raise lu_error_out per the rule above.

Decomposition:
- Shared package rv32_pkg:
  - REG_IDX_W=5, NUM_REGS=32;
  - typedef reg_idx_t (logic [4:0]);
  - typedef wb_req_t {reg_idx_t rd; logic wr; logic [31:0] value}.
- One natural sub-module: rv32_scoreboard (32-bit pending vector, set/clear/lookup, x0 masking).
- Arbitration and the output register remain in rv32_writeback_arb.

Test Plan:
- Reset, then pipeline write rd=5, value 0xDEADBEEF -> next cycle rd_out=5, rd_write_out=1, rd_value_out=0xDEADBEEF; the cycle after, rd_write_out=0.
- Pipeline write rd=3 with writeback_flush_in=1 -> rd_write_out stays 0; with mem_rd_in=0 -> no write.
- Issue LU rd=7; decode rs1=7 -> hazard_stall_out=1 until the result for rd=7 (0x12345678) is accepted, then rd_value_out=0x12345678. hazard_stall_out is 0 the cycle after the write lands.
- LU result valid rd=9 in the same cycle as a pipeline write rd=4 -> ready=0, pipeline written first; LU accepted next cycle; rd_out sequence 4 then 9; pending[9] cleared.
- LU result for rd=11 never issued -> lu_error_out=1 and stays 1; rd 11 is written.
- Issue rd=2 and accept an old result for rd=2 in the same cycle -> pending[2] remains 1; hazard on rs2=2 persists.
